ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the send side of the keyboard link, opposite the existing PS/2 receive path.
- It sends single command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- It produces open-collector drive enables. The top level assigns the inouts: PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz, and likewise for PS2_DAT.
- busy is routed to the receive controller so that it ignores line activity during a transmit.

---
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. It inhibits the bus, requests to send, then shifts out one
// command frame on device clock falls and checks the device ACK. Line drives are open-collector enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES    = 6000,
    parameter int FIRST_CLK_TIMEOUT = 750000,
    parameter int XFER_TIMEOUT      = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CNT_MAX = (FIRST_CLK_TIMEOUT > INHIBIT_CYCLES) ? FIRST_CLK_TIMEOUT : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int XFER_W  = $clog2(XFER_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  INH_START  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0]  INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FIRST_LAST = CNT_W'(FIRST_CLK_TIMEOUT - 1);
    localparam logic [XFER_W-1:0] XFER_LAST  = XFER_W'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    // Index 0 is CLK, index 1 is DAT; both idle high, so the synchronizers reset to 1.
    logic [1:0] line_raw;
    logic [1:0] line_sync;
    assign line_raw = {ps2_dat_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= line_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign line_sync[gi] = sync_reg;
        end
    endgenerate

    logic clk_sync;
    logic dat_sync;
    logic clk_prev_reg;
    logic fall;
    assign clk_sync = line_sync[0];
    assign dat_sync = line_sync[1];
    assign fall     = clk_prev_reg & ~clk_sync;

    state_t             state_reg;
    logic [10:0]        frame_reg;
    logic [3:0]         bit_cnt_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [XFER_W-1:0]  xfer_cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               error_reg;
    logic [1:0]         code_reg;
    logic               clk_oe_reg;
    logic               dat_oe_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            frame_reg    <= '0;
            bit_cnt_reg  <= '0;
            cnt_reg      <= '0;
            xfer_cnt_reg <= '0;
            clk_prev_reg <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            code_reg     <= 2'b00;
            clk_oe_reg   <= 1'b0;
            dat_oe_reg   <= 1'b0;
        end else begin
            clk_prev_reg <= clk_sync;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    clk_oe_reg <= 1'b0;
                    dat_oe_reg <= 1'b0;
                    if (send) begin
                        frame_reg  <= {1'b1, ~^cmd_data, cmd_data, 1'b0};
                        busy_reg   <= 1'b1;
                        code_reg   <= 2'b00;
                        cnt_reg    <= '0;
                        clk_oe_reg <= 1'b1;
                        state_reg  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // Start bit goes low one cycle before CLK is released.
                    if (cnt_reg == INH_START) begin
                        dat_oe_reg <= 1'b1;
                    end
                    if (cnt_reg == INH_LAST) begin
                        clk_oe_reg <= 1'b0;
                        dat_oe_reg <= 1'b1;
                        cnt_reg    <= '0;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (fall) begin
                        dat_oe_reg   <= ~frame_reg[1];
                        bit_cnt_reg  <= 4'd2;
                        xfer_cnt_reg <= '0;
                        state_reg    <= SHIFT;
                    end else if (cnt_reg == FIRST_LAST) begin
                        clk_oe_reg <= 1'b0;
                        dat_oe_reg <= 1'b0;
                        error_reg  <= 1'b1;
                        code_reg   <= 2'b01;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                SHIFT, ACK, WAIT_IDLE: begin
                    xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
                    if (xfer_cnt_reg == XFER_LAST) begin
                        clk_oe_reg <= 1'b0;
                        dat_oe_reg <= 1'b0;
                        error_reg  <= 1'b1;
                        code_reg   <= 2'b10;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end else if (state_reg == SHIFT) begin
                        // Frame bit 10 is the stop bit (1), so the tenth fall releases DAT.
                        if (fall) begin
                            dat_oe_reg <= ~frame_reg[bit_cnt_reg];
                            if (bit_cnt_reg == 4'd10) begin
                                state_reg <= ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end else if (state_reg == ACK) begin
                        if (fall) begin
                            if (!dat_sync) begin
                                state_reg <= WAIT_IDLE;
                            end else begin
                                clk_oe_reg <= 1'b0;
                                dat_oe_reg <= 1'b0;
                                error_reg  <= 1'b1;
                                code_reg   <= 2'b11;
                                busy_reg   <= 1'b0;
                                state_reg  <= IDLE;
                            end
                        end
                    end else if (clk_sync && dat_sync) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign error_code = code_reg;
    assign ps2_clk_oe = clk_oe_reg;
    assign ps2_dat_oe = dat_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a scoreboard
// holds the frame and outcome expected for each accepted send.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int FTMO = 400;
    localparam int XTMO = 2000;
    localparam int HALF = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       busy, done, error;
    logic [1:0] error_code;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       bfm_clk_drv = 1'b1;
    logic       bfm_dat_drv = 1'b1;
    logic       clk_line, dat_line;

    assign clk_line = ~ps2_clk_oe & bfm_clk_drv;
    assign dat_line = ~ps2_dat_oe & bfm_dat_drv;

    ps2_host_tx #(
        .INHIBIT_CYCLES   (INH),
        .FIRST_CLK_TIMEOUT(FTMO),
        .XFER_TIMEOUT     (XTMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .send      (send),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .error_code(error_code),
        .ps2_clk_in(clk_line),
        .ps2_dat_in(dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic [10:0] frame;
        logic [10:0] mask;
        logic [1:0]  code;
    } exp_t;
    exp_t exp_q[$];

    // Line monitor: inhibit length, release time, pulse counts.
    int   hold_cnt = 0, inhibit_len = 0, rel_cyc = 0, rel_count = 0;
    int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic dat_at_hold_end = 1'b0, dat_before_rel = 1'b0, prev_clk_oe = 1'b0;

    always @(negedge clock) begin
        if (ps2_clk_oe) begin
            hold_cnt++;
            dat_at_hold_end = ps2_dat_oe;
        end else if (prev_clk_oe) begin
            inhibit_len    = hold_cnt;
            dat_before_rel = dat_at_hold_end;
            rel_cyc        = cyc;
            rel_count++;
            hold_cnt       = 0;
        end
        prev_clk_oe = ps2_clk_oe;
        if (done && error) both_cnt++;
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Outcome of the last transfer, filled by wait_end.
    logic       got_done, got_err, end_busy, pre_busy, end_clk_oe, end_dat_oe;
    logic [1:0] end_code;
    int         end_cyc;

    task automatic wait_end();
        logic last_busy;
        got_done = 1'b0;
        got_err  = 1'b0;
        last_busy = busy;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            if (done || error) begin
                got_done   = done;
                got_err    = error;
                end_busy   = busy;
                pre_busy   = last_busy;
                end_clk_oe = ps2_clk_oe;
                end_dat_oe = ps2_dat_oe;
                end_code   = error_code;
                end_cyc    = cyc;
                return;
            end
            last_busy = busy;
        end
        check("end_seen", {31'b0, done | error}, 32'd1);
    endtask

    task automatic send_cmd(input logic [7:0] d, input bit push, input logic [10:0] mask,
                            input logic [1:0] code);
        exp_t e;
        @(negedge clock);
        send = 1'b1;
        cmd_data = d;
        if (push) begin
            e.frame = {1'b1, ~^d, d, 1'b0};
            e.mask  = mask;
            e.code  = code;
            exp_q.push_back(e);
        end
        @(negedge clock);
        send = 1'b0;
    endtask

    // Device model: waits for the host request, then produces n_falls clock periods,
    // sampling DAT before each rise; the eleventh period carries the ACK.
    logic [10:0] bfm_bits;
    int          bfm_first_fall;

    task automatic bfm(input int n_falls, input bit ack_low);
        bfm_bits = '0;
        bfm_first_fall = 0;
        for (int i = 0; i < 2000 && !(clk_line && !dat_line); i++) @(posedge clock);
        check("bfm_request", {30'b0, clk_line, dat_line}, 32'b10);
        bfm_bits[0] = dat_line;
        for (int k = 1; k <= n_falls && k <= 11; k++) begin
            if (k == 11) begin
                repeat (HALF / 2) @(posedge clock);
                bfm_dat_drv = ack_low ? 1'b0 : 1'b1;
                repeat (HALF / 2) @(posedge clock);
            end else begin
                repeat (HALF) @(posedge clock);
            end
            bfm_clk_drv = 1'b0;
            if (k == 1) bfm_first_fall = cyc;
            repeat (HALF) @(posedge clock);
            if (k <= 10) bfm_bits[k] = dat_line;
            bfm_clk_drv = 1'b1;
        end
        if (n_falls >= 11) begin
            repeat (HALF / 2) @(posedge clock);
            bfm_dat_drv = 1'b1;
        end
    endtask

    task automatic score(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_frame"}, {21'b0, bfm_bits & e.mask}, {21'b0, e.frame & e.mask});
            check({tag, "_done"}, {31'b0, got_done}, {31'b0, e.code == 2'b00});
            check({tag, "_error"}, {31'b0, got_err}, {31'b0, e.code != 2'b00});
            check({tag, "_code"}, {30'b0, end_code}, {30'b0, e.code});
            check({tag, "_busy_end"}, {31'b0, end_busy}, 32'd0);
            if (e.code != 2'b00)
                check({tag, "_lines_rel"}, {30'b0, end_clk_oe, end_dat_oe}, 32'd0);
        end
    endtask

    initial begin
        int d;
        int done_before;
        repeat (3) @(negedge clock);
        check("reset_outputs", {24'b0, busy, done, error, error_code, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // 1: 0xED with ACK
        done_before = done_cnt;
        send_cmd(8'hED, 1'b1, 11'h7FF, 2'b00);
        fork
            bfm(11, 1'b1);
            wait_end();
        join
        $display("txn 0xED: done=%0b err=%0b code=%0d bits=%03h", got_done, got_err, end_code, bfm_bits);
        score("ed");
        check("ed_inhibit_len", inhibit_len, INH);
        check("ed_dat_low_before_rel", {31'b0, dat_before_rel}, 32'd1);
        check("ed_parity", {31'b0, bfm_bits[9]}, 32'd1);
        check("ed_busy_before_done", {31'b0, pre_busy}, 32'd1);
        repeat (20) @(negedge clock);
        check("ed_done_once", done_cnt - done_before, 32'd1);

        // 2: 0xFF with an ignored send while busy, then 0x00
        d = rel_count;
        send_cmd(8'hFF, 1'b1, 11'h7FF, 2'b00);
        repeat (5) @(negedge clock);
        send_cmd(8'h00, 1'b0, 11'h7FF, 2'b00);
        fork
            bfm(11, 1'b1);
            wait_end();
        join
        $display("txn 0xFF: done=%0b err=%0b code=%0d bits=%03h", got_done, got_err, end_code, bfm_bits);
        score("ff");
        check("ff_parity", {31'b0, bfm_bits[9]}, 32'd1);
        repeat (100) @(negedge clock);
        check("ff_single_frame", rel_count - d, 32'd1);
        check("ff_idle_after", {30'b0, busy, ps2_clk_oe}, 32'd0);
        send_cmd(8'h00, 1'b1, 11'h7FF, 2'b00);
        fork
            bfm(11, 1'b1);
            wait_end();
        join
        $display("txn 0x00: done=%0b err=%0b code=%0d bits=%03h", got_done, got_err, end_code, bfm_bits);
        score("zero");
        check("zero_parity", {31'b0, bfm_bits[9]}, 32'd1);

        // 3: device never clocks
        bfm_bits = '0;
        send_cmd(8'hF4, 1'b1, 11'h000, 2'b01);
        wait_end();
        $display("txn 0xF4 no-clock: done=%0b err=%0b code=%0d", got_done, got_err, end_code);
        score("noclk");
        check("noclk_delay", end_cyc - rel_cyc, FTMO);
        repeat (10) @(negedge clock);
        check("noclk_code_held", {30'b0, error_code}, 32'd1);

        // 4: no ACK from device
        send_cmd(8'hA5, 1'b1, 11'h7FF, 2'b11);
        repeat (3) @(negedge clock);
        check("noack_code_cleared", {30'b0, error_code}, 32'd0);
        done_before = done_cnt;
        fork
            bfm(11, 1'b0);
            wait_end();
        join
        $display("txn 0xA5 no-ack: done=%0b err=%0b code=%0d bits=%03h", got_done, got_err, end_code, bfm_bits);
        score("noack");
        repeat (40) @(negedge clock);
        check("noack_no_done", done_cnt - done_before, 32'd0);

        // 5: device stops after 5 falls
        send_cmd(8'h3C, 1'b1, 11'h01F, 2'b10);
        fork
            bfm(5, 1'b1);
            wait_end();
        join
        $display("txn 0x3C stall: done=%0b err=%0b code=%0d bits=%03h", got_done, got_err, end_code, bfm_bits);
        score("stall");
        d = end_cyc - bfm_first_fall;
        check("stall_window", {31'b0, d >= XTMO && d <= XTMO + 6}, 32'd1);

        // 6: reset in the middle of SHIFT, then a normal transfer
        send_cmd(8'h00, 1'b0, 11'h7FF, 2'b00);
        bfm(4, 1'b1);
        repeat (5) @(negedge clock);
        check("mid_shift_state", {30'b0, busy, ps2_dat_oe}, 32'b11);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("async_reset_release", {29'b0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        $display("txn reset mid-shift: busy=%0b clk_oe=%0b dat_oe=%0b", busy, ps2_clk_oe, ps2_dat_oe);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        send_cmd(8'hF4, 1'b1, 11'h7FF, 2'b00);
        fork
            bfm(11, 1'b1);
            wait_end();
        join
        $display("txn 0xF4 after reset: done=%0b err=%0b code=%0d bits=%03h", got_done, got_err, end_code, bfm_bits);
        score("f4");

        check("done_error_exclusive", both_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
